// File: rtl/tx_frame_sequencer_if.sv
// tx_frame_sequencer_if: valid/ready stream carrying one W-bit word
//   valid, data : driven by master
//   ready       : driven by slave
interface tx_frame_sequencer_if #(parameter int W = 32);
  logic valid;
  logic ready;
  logic [W-1:0] data;
  modport master(output valid, output data, input ready);
  modport slave(input valid, input data, output ready);
endinterface

// File: rtl/tx_frame_sequencer.sv
// tx_frame_sequencer: runs a payload through the serial CRC, forms {payload, crc} and feeds it plus a zero tail to the encoder
//   clk, reset          : clock, synchronous active-high reset
//   abort               : returns to IDLE from any busy state
//   in_s  (slave)       : payload handshake, ready only in IDLE
//   out_s (master)      : encoded-frame handshake, data = captured {payload, crc}
//   crc_init/en/bit     : CRC engine control and serial data; crc_value is its result
//   enc_init/en/bit     : encoder control and serial data
//   busy                : high outside IDLE
module tx_frame_sequencer #(
  parameter int PAYLOAD_W = 32,
  parameter int CRC_W = 16,
  parameter int TAIL_BITS = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic abort,
  tx_frame_sequencer_if.slave in_s,
  tx_frame_sequencer_if.master out_s,
  output logic crc_init,
  output logic crc_en,
  output logic crc_bit,
  input  logic [CRC_W-1:0] crc_value,
  output logic enc_init,
  output logic enc_en,
  output logic enc_bit,
  output logic busy
);
  localparam int F = PAYLOAD_W + CRC_W;
  localparam int CW = $clog2(F);
  typedef enum logic [2:0] {IDLE, CRC_INIT, CRC_SHIFT, CAPTURE, ENC_INIT, ENC_SHIFT, ENC_TAIL, DONE} state_t;
  state_t st, nxt;
  logic [CW-1:0] cnt, ld;
  logic [F-1:0] sr, frame;
  logic last;
  always_comb begin
    last = cnt == '0;
    nxt = st;
    case (st)
      IDLE:      nxt = in_s.valid ? CRC_INIT : IDLE;
      CRC_INIT:  nxt = CRC_SHIFT;
      CRC_SHIFT: nxt = last ? CAPTURE : CRC_SHIFT;
      CAPTURE:   nxt = ENC_INIT;
      ENC_INIT:  nxt = ENC_SHIFT;
      ENC_SHIFT: nxt = last ? ENC_TAIL : ENC_SHIFT;
      ENC_TAIL:  nxt = last ? DONE : ENC_TAIL;
      DONE:      nxt = out_s.ready ? IDLE : DONE;
      default:   nxt = IDLE;
    endcase
    if (abort && st != IDLE) nxt = IDLE;
    ld = nxt == CRC_SHIFT ? CW'(PAYLOAD_W - 1) :
         nxt == ENC_SHIFT ? CW'(F - 1) :
         nxt == ENC_TAIL  ? CW'(TAIL_BITS - 1) : '0;
  end
  // The payload field rotates during CRC_SHIFT so it is intact again at CAPTURE.
  always_ff @(posedge clk)
    if (reset) begin
      st <= IDLE;
      cnt <= '0;
      sr <= '0;
      frame <= '0;
    end else begin
      st <= nxt;
      cnt <= nxt != st ? ld : last ? cnt : cnt - 1'b1;
      if (st == IDLE && in_s.valid) sr <= {in_s.data, {CRC_W{1'b0}}};
      if (st == CRC_SHIFT) sr[F-1 -: PAYLOAD_W] <= {sr[F-2 -: PAYLOAD_W-1], sr[F-1]};
      if (st == CAPTURE && !abort) begin
        sr <= {sr[F-1 -: PAYLOAD_W], crc_value};
        frame <= {sr[F-1 -: PAYLOAD_W], crc_value};
      end
      if (st == ENC_SHIFT) sr <= sr << 1;
    end
  assign in_s.ready = st == IDLE;
  assign busy = st != IDLE;
  assign crc_init = st == CRC_INIT;
  assign crc_en = st == CRC_SHIFT;
  assign crc_bit = st == CRC_SHIFT && sr[F-1];
  assign enc_init = st == ENC_INIT;
  assign enc_en = st == ENC_SHIFT || st == ENC_TAIL;
  assign enc_bit = st == ENC_SHIFT && sr[F-1];
  assign out_s.valid = st == DONE;
  assign out_s.data = frame;
endmodule

// File: tb/tb_tx_frame_sequencer.sv
// tb_tx_frame_sequencer: randomized scoreboard bench with CRC-16 engine and K=5 rate-1/2 encoder models
module tb_tx_frame_sequencer;
  localparam int PW = 32, CW = 16, TB = 4, F = PW + CW, NE = F + TB;
  localparam logic [16:0] POLY = 17'h11021;
  localparam logic [4:0] G0 = 5'b10011, G1 = 5'b11101;
  typedef struct {
    logic [PW-1:0] payload;
    logic [F-1:0] frame;
    logic [2*NE-1:0] code;
  } exp_t;
  logic clk = 0, reset = 1, abort = 0, use_fixed = 0;
  logic crc_init, crc_en, crc_bit, enc_init, enc_en, enc_bit, busy;
  logic [CW-1:0] crc_value, crc_reg = '0;
  logic [3:0] es = '0;
  logic [4:0] win;
  int compared = 0, mismatched = 0;
  exp_t sb[$];
  tx_frame_sequencer_if #(PW) in_s ();
  tx_frame_sequencer_if #(F) out_s ();
  tx_frame_sequencer dut (
    .clk(clk), .reset(reset), .abort(abort), .in_s(in_s), .out_s(out_s),
    .crc_init(crc_init), .crc_en(crc_en), .crc_bit(crc_bit), .crc_value(crc_value),
    .enc_init(enc_init), .enc_en(enc_en), .enc_bit(enc_bit), .busy(busy)
  );
  always #5 clk = ~clk;
  always @(posedge clk)
    if (crc_init) crc_reg <= 16'hFFFF;
    else if (crc_en) crc_reg <= {crc_reg[14:0], 1'b0} ^ ((crc_reg[15] ^ crc_bit) ? 16'h1021 : 16'h0000);
  assign crc_value = use_fixed ? 16'hBEEF : crc_reg;
  always @(posedge clk)
    if (enc_init) es <= '0;
    else if (enc_en) es <= {es[2:0], enc_bit};
  assign win = {es, enc_bit};
  function automatic logic [CW-1:0] crc16(input logic [PW-1:0] p);
    logic [F-1:0] m;
    m = {p, 16'h0000} ^ {16'hFFFF, 32'h0};
    for (int i = F - 1; i >= CW; i--) if (m[i]) m = m ^ (F'(POLY) << (i - CW));
    return m[CW-1:0];
  endfunction
  function automatic logic [2*NE-1:0] encode(input logic [F-1:0] fr);
    logic u[NE];
    logic [2*NE-1:0] c;
    logic a, b;
    c = '0;
    for (int i = 0; i < NE; i++) u[i] = i < F ? fr[F-1-i] : 1'b0;
    for (int i = 0; i < NE; i++) begin
      a = 0;
      b = 0;
      for (int k = 0; k < 5; k++)
        if (i >= k) begin
          a = a ^ (G0[k] & u[i-k]);
          b = b ^ (G1[k] & u[i-k]);
        end
      c = {c[2*NE-3:0], a, b};
    end
    return c;
  endfunction
  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask
  task automatic fail_now(input string nm);
    compared++;
    mismatched++;
    $display("FAIL %s: got no response, expected one within 200 cycles", nm);
  endtask
  int cyc = 0, n_ci, n_ce, n_ei, n_ee, f_ci, f_ce, f_ei, f_ee;
  logic [PW-1:0] cs;
  logic [NE-1:0] ds;
  logic [2*NE-1:0] eo;
  logic seen;
  exp_t cur;
  initial begin
    seen = 0;
    forever begin
      @(negedge clk);
      if (reset) seen = 0;
      else begin
        cyc++;
        if (crc_init) begin if (n_ci == 0) f_ci = cyc; n_ci++; end
        if (crc_en) begin if (n_ce == 0) f_ce = cyc; n_ce++; cs = {cs[PW-2:0], crc_bit}; end
        if (enc_init) begin if (n_ei == 0) f_ei = cyc; n_ei++; end
        if (enc_en) begin
          if (n_ee == 0) f_ee = cyc;
          n_ee++;
          ds = {ds[NE-2:0], enc_bit};
          eo = {eo[2*NE-3:0], ^(win & G0), ^(win & G1)};
        end
        if (in_s.ready)
          chk("idle_outputs", 128'({crc_init, crc_en, crc_bit, enc_init, enc_en, enc_bit, out_s.valid, busy}), 128'(0));
        if (out_s.valid && !seen) begin
          seen = 1;
          if (sb.size() == 0) begin
            compared++;
            mismatched++;
            $display("FAIL out_valid_unexpected: got out_valid=1, expected 0");
          end else begin
            cur = sb.pop_front();
            chk("latency", 128'(cyc), 128'(PW + F + TB + 4));
            chk("out_frame", 128'(out_s.data), 128'(cur.frame));
            chk("crc_bits", 128'(cs), 128'(cur.payload));
            chk("enc_bits", 128'(ds), 128'({cur.frame, {TB{1'b0}}}));
            chk("enc_code", 128'(eo), 128'(cur.code));
            chk("crc_init_count", 128'(n_ci), 128'(1));
            chk("crc_init_cycle", 128'(f_ci), 128'(1));
            chk("crc_en_count", 128'(n_ce), 128'(PW));
            chk("crc_en_first", 128'(f_ce), 128'(2));
            chk("enc_init_count", 128'(n_ei), 128'(1));
            chk("enc_init_cycle", 128'(f_ei), 128'(PW + 3));
            chk("enc_en_count", 128'(n_ee), 128'(NE));
            chk("enc_en_first", 128'(f_ee), 128'(PW + 4));
          end
        end else if (out_s.valid) begin
          chk("frame_hold", 128'(out_s.data), 128'(cur.frame));
          chk("in_ready_in_done", 128'(in_s.ready), 128'(0));
        end
        if (!out_s.valid) seen = 0;
        if (in_s.valid && in_s.ready) begin
          cyc = 0;
          {n_ci, n_ce, n_ei, n_ee, f_ci, f_ce, f_ei, f_ee} = '0;
        end
      end
    end
  end
  task automatic send(input logic [PW-1:0] p, input int hold, input int stop_at, input bit with_reset, input bit idle_abort);
    exp_t e;
    int n;
    e.payload = p;
    e.frame = {p, use_fixed ? 16'hBEEF : crc16(p)};
    e.code = encode(e.frame);
    @(posedge clk); #1;
    in_s.valid = 1;
    in_s.data = p;
    abort = idle_abort;
    out_s.ready = hold == 0;
    n = 0;
    @(negedge clk);
    while (!in_s.ready && n < 200) begin @(negedge clk); n++; end
    if (!in_s.ready) begin fail_now("accept_timeout"); in_s.valid = 0; return; end
    sb.push_back(e);
    @(posedge clk); #1;
    in_s.valid = 0;
    in_s.data = $urandom;
    abort = 0;
    if (stop_at > 0) begin
      repeat (stop_at - 1) @(posedge clk);
      #1;
      reset = with_reset;
      abort = 1;
      @(posedge clk); #1;
      reset = 0;
      abort = 0;
      @(negedge clk);
      chk("stop_in_ready", 128'(in_s.ready), 128'(1));
      chk("stop_busy", 128'(busy), 128'(0));
      chk("stop_enables", 128'({crc_en, enc_en, enc_init, out_s.valid}), 128'(0));
      if (with_reset) chk("reset_out_frame", 128'(out_s.data), 128'(0));
      void'(sb.pop_back());
      repeat (3) @(negedge clk);
      chk("stop_no_valid", 128'({out_s.valid, busy}), 128'(0));
      return;
    end
    n = 0;
    @(negedge clk);
    while (!out_s.valid && n < 200) begin @(negedge clk); n++; end
    if (!out_s.valid) begin fail_now("out_valid_timeout"); return; end
    if (hold > 0) begin
      @(posedge clk); #1;
      in_s.valid = 1;
      in_s.data = $urandom;
      repeat (hold - 1) @(posedge clk);
      #1;
      in_s.valid = 0;
      out_s.ready = 1;
    end
    @(posedge clk); #1;
    @(negedge clk);
    chk("after_done", 128'({in_s.ready, out_s.valid, busy}), 128'(3'b100));
  endtask
  initial begin
    in_s.valid = 0;
    in_s.data = '0;
    out_s.ready = 1;
    repeat (2) @(posedge clk);
    #1;
    reset = 0;
    repeat (5) @(negedge clk);
    chk("rst_in_ready", 128'(in_s.ready), 128'(1));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_ctrl", 128'({crc_init, crc_en, crc_bit, enc_init, enc_en, enc_bit, out_s.valid}), 128'(0));
    chk("rst_out_frame", 128'(out_s.data), 128'(0));
    use_fixed = 1;
    send(32'h80000001, 0, 0, 0, 0);
    use_fixed = 0;
    send(32'h12345678, 0, 0, 0, 0);
    send($urandom, 10, 0, 0, 0);
    send($urandom, 0, 40, 0, 0);
    send($urandom, 0, 0, 0, 0);
    send($urandom, 0, 0, 0, 1);
    send($urandom, 0, 20, 1, 0);
    for (int i = 0; i < 8; i++) send($urandom, $urandom_range(0, 1) == 0 ? 0 : int'($urandom_range(2, 5)), 0, 0, i % 3 == 0);
    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
